// File: rtl/vram_arbiter.sv
// Arbitrates the external VRAM bus between asynchronous MPU strobes and synchronous GPU reads.
// GPU wins during active display, MPU wins during blanking, and a wait counter bounds MPU starvation.
module vram_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_MPU_WAIT  = 16
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic                  _mpu_en,
    input  logic                  _mpu_rd,
    input  logic                  _mpu_wr,
    input  logic [1:0]            _mpu_be,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic [DATA_WIDTH-1:0] mpu_rdata,
    output logic                  mpu_busy,
    output logic                  mpu_overrun,
    input  logic                  gpu_req,
    input  logic [ADDR_WIDTH-1:0] gpu_addr,
    output logic                  gpu_ack,
    output logic [DATA_WIDTH-1:0] gpu_rdata,
    output logic                  _vram_en,
    output logic                  _vram_rd,
    output logic                  _vram_wr,
    output logic [1:0]            _vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_wdata,
    output logic                  vram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] vram_rdata
);

    localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MAX_MPU_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MPU_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GPU_ACC = 2'd1,
        ST_MPU_ACC = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Synchronizer for the asynchronous enable, plus one stage of history for edge detection
    logic                  en_sync1_q, en_sync1_d;
    logic                  en_sync2_q, en_sync2_d;
    logic                  en_prev_q, en_prev_d;

    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;

    // Pending MPU request, latched on the synchronized enable edge
    logic                  req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [1:0]            req_be_q, req_be_d;

    // Access currently on the bus, latched at grant
    logic                  acc_write_q, acc_write_d;
    logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_WIDTH-1:0] vram_wdata_q, vram_wdata_d;
    logic [1:0]            vram_be_q, vram_be_d;

    logic [DATA_WIDTH-1:0] mpu_rdata_q, mpu_rdata_d;
    logic [DATA_WIDTH-1:0] gpu_rdata_q, gpu_rdata_d;
    logic                  gpu_ack_q, gpu_ack_d;

    logic                  en_rise;
    logic                  mpu_strobe;
    logic                  last_acc;
    logic                  mpu_wins;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        en_sync1_d   = ~_mpu_en;
        en_sync2_d   = en_sync1_q;
        en_prev_d    = en_sync2_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        wait_d       = wait_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_be_d     = req_be_q;
        acc_write_d  = acc_write_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        vram_be_d    = vram_be_q;
        mpu_rdata_d  = mpu_rdata_q;
        gpu_rdata_d  = gpu_rdata_q;
        gpu_ack_d    = 1'b0;

        en_rise    = en_sync2_q & ~en_prev_q;
        mpu_strobe = ~_mpu_rd | ~_mpu_wr;
        last_acc   = (cnt_q == CNT_LAST);
        mpu_wins   = busy_q & (hblank | vblank | (wait_q >= WAIT_MAX) | ~gpu_req);

        if (busy_q && (state_q != ST_MPU_ACC) && (wait_q < WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (mpu_wins) begin
                    state_d      = ST_MPU_ACC;
                    cnt_d        = '0;
                    acc_write_d  = req_write_q;
                    vram_addr_d  = req_addr_q;
                    vram_wdata_d = req_wdata_q;
                    vram_be_d    = req_be_q;
                end else if (gpu_req) begin
                    state_d     = ST_GPU_ACC;
                    cnt_d       = '0;
                    acc_write_d = 1'b0;
                    vram_addr_d = gpu_addr;
                    vram_be_d   = 2'b00;
                end
            end
            ST_GPU_ACC: begin
                if (last_acc) begin
                    state_d     = ST_IDLE;
                    gpu_ack_d   = 1'b1;
                    gpu_rdata_d = vram_rdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MPU_ACC: begin
                if (last_acc) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!acc_write_q) begin
                        mpu_rdata_d = vram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new edge while the previous request is still outstanding is dropped
        if (en_rise && mpu_strobe) begin
            if (busy_q) begin
                overrun_d = 1'b1;
            end else begin
                busy_d      = 1'b1;
                wait_d      = '0;
                req_write_d = ~_mpu_wr;
                req_addr_d  = mpu_addr;
                req_wdata_d = mpu_wdata;
                req_be_d    = _mpu_be;
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            en_sync1_q   <= 1'b0;
            en_sync2_q   <= 1'b0;
            en_prev_q    <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            wait_q       <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_be_q     <= 2'b11;
            acc_write_q  <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            vram_be_q    <= 2'b11;
            mpu_rdata_q  <= '0;
            gpu_rdata_q  <= '0;
            gpu_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_sync1_q   <= en_sync1_d;
            en_sync2_q   <= en_sync2_d;
            en_prev_q    <= en_prev_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            wait_q       <= wait_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_be_q     <= req_be_d;
            acc_write_q  <= acc_write_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            vram_be_q    <= vram_be_d;
            mpu_rdata_q  <= mpu_rdata_d;
            gpu_rdata_q  <= gpu_rdata_d;
            gpu_ack_q    <= gpu_ack_d;
        end
    end

    // Strobes decode straight from the state register so reset releases the bus immediately
    always_comb begin
        _vram_en      = 1'b1;
        _vram_rd      = 1'b1;
        _vram_wr      = 1'b1;
        _vram_be      = 2'b11;
        vram_wdata_oe = 1'b0;
        case (state_q)
            ST_GPU_ACC: begin
                _vram_en = 1'b0;
                _vram_rd = 1'b0;
                _vram_be = vram_be_q;
            end
            ST_MPU_ACC: begin
                _vram_en = 1'b0;
                _vram_be = vram_be_q;
                if (acc_write_q) begin
                    _vram_wr      = 1'b0;
                    vram_wdata_oe = 1'b1;
                end else begin
                    _vram_rd = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign vram_addr   = vram_addr_q;
    assign vram_wdata  = vram_wdata_q;
    assign mpu_rdata   = mpu_rdata_q;
    assign mpu_busy    = busy_q;
    assign mpu_overrun = overrun_q;
    assign gpu_ack     = gpu_ack_q;
    assign gpu_rdata   = gpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized MPU/GPU/blanking traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int AC = 2;
    localparam int MW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          _reset, hblank, vblank;
    logic          _mpu_en, _mpu_rd, _mpu_wr;
    logic [1:0]    _mpu_be;
    logic [AW-1:0] mpu_addr, gpu_addr, vram_addr;
    logic [DW-1:0] mpu_wdata, mpu_rdata, gpu_rdata, vram_wdata, vram_rdata;
    logic          mpu_busy, mpu_overrun, gpu_req, gpu_ack;
    logic          _vram_en, _vram_rd, _vram_wr, vram_wdata_oe;
    logic [1:0]    _vram_be;
    logic          rd_ovr_en;
    logic [DW-1:0] rd_ovr;

    function automatic logic [DW-1:0] scramble(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign vram_rdata = rd_ovr_en ? rd_ovr : scramble(vram_addr);

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC), .MAX_MPU_WAIT(MW)) dut (
        .clk(clk), ._reset(_reset), .hblank(hblank), .vblank(vblank),
        ._mpu_en(_mpu_en), ._mpu_rd(_mpu_rd), ._mpu_wr(_mpu_wr), ._mpu_be(_mpu_be),
        .mpu_addr(mpu_addr), .mpu_wdata(mpu_wdata), .mpu_rdata(mpu_rdata),
        .mpu_busy(mpu_busy), .mpu_overrun(mpu_overrun),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_ack(gpu_ack), .gpu_rdata(gpu_rdata),
        ._vram_en(_vram_en), ._vram_rd(_vram_rd), ._vram_wr(_vram_wr), ._vram_be(_vram_be),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_wdata_oe(vram_wdata_oe),
        .vram_rdata(vram_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_valid = 0;
    bit          h1, h2, h3;              // ~_mpu_en as seen at the last three edges
    bit          m_pend, m_pend_wr;
    logic [15:0] m_pend_addr, m_pend_data;
    logic [1:0]  m_pend_be;
    int          m_wait;
    bit          m_ovr;
    int          m_who;                   // 0 bus free, 1 GPU owns it, 2 MPU owns it
    int          m_left;                  // access cycles still to run
    logic [15:0] m_acc_addr, m_acc_data;
    logic [1:0]  m_acc_be;
    bit          m_acc_wr;
    bit          m_ack;
    logic [15:0] m_grd, m_mrd;

    task automatic model_reset();
        h1 = 0; h2 = 0; h3 = 0;
        m_pend = 0; m_pend_wr = 0; m_pend_addr = 0; m_pend_data = 0; m_pend_be = 2'b11;
        m_wait = 0; m_ovr = 0; m_who = 0; m_left = 0;
        m_acc_addr = 0; m_acc_data = 0; m_acc_be = 2'b11; m_acc_wr = 0;
        m_ack = 0; m_grd = 0; m_mrd = 0;
        m_valid = 1;
    endtask

    task automatic model_step();
        bit rise, strobe, old_pend;
        int old_who, old_wait;
        logic [15:0] rd_val;
        if (!_reset) begin
            model_reset();
            return;
        end
        rise     = h2 && !h3;
        h3 = h2; h2 = h1; h1 = !_mpu_en;
        strobe   = !_mpu_rd || !_mpu_wr;
        old_pend = m_pend;
        old_who  = m_who;
        old_wait = m_wait;
        rd_val   = rd_ovr_en ? rd_ovr : scramble(m_acc_addr);
        m_ack    = 0;
        if (m_who != 0 && m_left == 1) begin
            if (m_who == 1) begin
                m_ack = 1;
                m_grd = rd_val;
            end else begin
                if (!m_acc_wr) m_mrd = rd_val;
                m_pend = 0;
            end
            m_who = 0;
        end else if (m_who != 0) begin
            m_left--;
        end else if (old_pend && (hblank || vblank || old_wait >= MW || !gpu_req)) begin
            m_who = 2; m_left = AC;
            m_acc_addr = m_pend_addr; m_acc_data = m_pend_data;
            m_acc_be = m_pend_be; m_acc_wr = m_pend_wr;
        end else if (gpu_req) begin
            m_who = 1; m_left = AC;
            m_acc_addr = gpu_addr; m_acc_be = 2'b00; m_acc_wr = 0;
        end
        if (old_pend && old_who != 2) m_wait = (old_wait + 1 > MW) ? MW : old_wait + 1;
        if (rise && strobe) begin
            if (old_pend) m_ovr = 1;
            else begin
                m_pend = 1; m_wait = 0;
                m_pend_wr = !_mpu_wr; m_pend_addr = mpu_addr;
                m_pend_data = mpu_wdata; m_pend_be = _mpu_be;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every negative edge while out of reset
    initial forever begin
        @(negedge clk);
        if (_reset && m_valid) begin
            chk("m_vram_en_n", _vram_en, m_who == 0);
            chk("m_vram_rd_n", _vram_rd, !(m_who == 1 || (m_who == 2 && !m_acc_wr)));
            chk("m_vram_wr_n", _vram_wr, !(m_who == 2 && m_acc_wr));
            chk("m_vram_be_n", _vram_be, (m_who == 0) ? 2'b11 : m_acc_be);
            chk("m_wdata_oe", vram_wdata_oe, m_who == 2 && m_acc_wr);
            if (m_who != 0) chk("m_vram_addr", vram_addr, m_acc_addr);
            if (m_who == 2 && m_acc_wr) chk("m_vram_wdata", vram_wdata, m_acc_data);
            chk("m_mpu_busy", mpu_busy, m_pend);
            chk("m_mpu_overrun", mpu_overrun, m_ovr);
            chk("m_gpu_ack", gpu_ack, m_ack);
            chk("m_gpu_rdata", gpu_rdata, m_grd);
            chk("m_mpu_rdata", mpu_rdata, m_mrd);
        end
    end

    // ---------------- stimulus agents ----------------
    int cyc = 0;
    bit gpu_auto = 0, gpu_keep = 0, mpu_auto = 0;
    int mpu_low_left = 0, mpu_gap = 0;

    task automatic gpu_drive();
        if (gpu_ack) begin
            if (gpu_keep || $urandom_range(0, 3) != 0) begin
                gpu_req = 1; gpu_addr = 16'($urandom);
            end else gpu_req = 0;
        end else if (!gpu_req) begin
            if (gpu_keep || $urandom_range(0, 2) == 0) begin
                gpu_req = 1; gpu_addr = 16'($urandom);
            end
        end else if (!gpu_keep && $urandom_range(0, 40) == 0) begin
            gpu_req = 0;
        end
    endtask

    task automatic mpu_drive();
        if (!_mpu_en) begin
            mpu_low_left--;
            if (mpu_low_left <= 0) begin
                _mpu_en = 1;
                mpu_gap = 3 + $urandom_range(0, 6);
            end
        end else if (mpu_gap > 0) begin
            mpu_gap--;
        end else if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 9))
                0:       begin _mpu_rd = 1; _mpu_wr = 1; end
                1, 2, 3: begin _mpu_rd = 1; _mpu_wr = 0; end
                default: begin _mpu_rd = 0; _mpu_wr = 1; end
            endcase
            _mpu_be = 2'($urandom);
            mpu_addr = 16'($urandom);
            mpu_wdata = 16'($urandom);
            mpu_low_left = $urandom_range(1, 5);
            _mpu_en = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (gpu_auto) gpu_drive();
        if (mpu_auto) mpu_drive();
    endtask

    task automatic mpu_start(input bit wr, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        _mpu_rd = wr; _mpu_wr = !wr; _mpu_be = be; mpu_addr = a; mpu_wdata = d; _mpu_en = 0;
    endtask

    task automatic wait_busy(input string name, input int limit);
        for (int i = 0; i < limit && !mpu_busy; i++) tick();
        chk(name, mpu_busy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, acks, last;
        bit seen;
        logic [15:0] wd, wa;
        _reset = 0; hblank = 0; vblank = 0;
        _mpu_en = 1; _mpu_rd = 1; _mpu_wr = 1; _mpu_be = 2'b11;
        mpu_addr = 0; mpu_wdata = 0; gpu_req = 0; gpu_addr = 0;
        rd_ovr_en = 0; rd_ovr = 0;
        repeat (3) tick();
        _reset = 1;
        tick();
        // reset state
        chk("rst_en_n", _vram_en, 1);   chk("rst_rd_n", _vram_rd, 1);
        chk("rst_wr_n", _vram_wr, 1);   chk("rst_be_n", _vram_be, 2'b11);
        chk("rst_oe", vram_wdata_oe, 0); chk("rst_busy", mpu_busy, 0);
        chk("rst_ovr", mpu_overrun, 0);  chk("rst_ack", gpu_ack, 0);
        chk("rst_addr", vram_addr, 0);   chk("rst_gpu_rdata", gpu_rdata, 0);
        $display("[TB] reset state checked");

        // GPU read with fixed VRAM data
        rd_ovr_en = 1; rd_ovr = 16'hBEEF; gpu_addr = 16'h1234; gpu_req = 1;
        tick();
        chk("t2_rd_c1", _vram_rd, 0); chk("t2_en_c1", _vram_en, 0);
        chk("t2_addr", vram_addr, 16'h1234); chk("t2_be", _vram_be, 2'b00);
        tick();
        chk("t2_rd_c2", _vram_rd, 0); chk("t2_noack_c2", gpu_ack, 0);
        tick();
        chk("t2_rd_c3", _vram_rd, 1); chk("t2_ack_c3", gpu_ack, 1);
        chk("t2_rdata", gpu_rdata, 16'hBEEF);
        gpu_req = 0; rd_ovr_en = 0;
        tick();
        chk("t2_ack_pulse", gpu_ack, 0);
        $display("[TB] GPU read 0x1234 -> %h", gpu_rdata);

        // MPU write during vblank wins over a waiting GPU request
        vblank = 1;
        mpu_start(1, 16'h0040, 16'h55AA, 2'b01);
        tick(); chk("t3_busy_e1", mpu_busy, 0);
        tick(); chk("t3_busy_e2", mpu_busy, 0);
        tick(); chk("t3_busy_e3", mpu_busy, 1);
        gpu_addr = 16'h0777; gpu_req = 1; _mpu_en = 1;
        tick();
        chk("t3_wr_n", _vram_wr, 0); chk("t3_rd_n", _vram_rd, 1);
        chk("t3_oe", vram_wdata_oe, 1); chk("t3_be", _vram_be, 2'b01);
        chk("t3_addr", vram_addr, 16'h0040); chk("t3_wdata", vram_wdata, 16'h55AA);
        tick();
        tick();
        chk("t3_busy_clr", mpu_busy, 0); chk("t3_wr_idle", _vram_wr, 1);
        tick(); chk("t3_gpu_addr", vram_addr, 16'h0777);
        tick(); tick();
        chk("t3_gpu_ack", gpu_ack, 1);
        gpu_req = 0; vblank = 0;
        tick();
        $display("[TB] MPU write 0x55AA@0x0040 granted before GPU");

        // Reset mid MPU write
        mpu_start(1, 16'h0100, 16'h1234, 2'b00);
        repeat (4) tick();
        chk("t1_wr_active", _vram_wr, 0);
        #2 _reset = 0;
        #1;
        chk("t1_wr_n", _vram_wr, 1); chk("t1_en_n", _vram_en, 1);
        chk("t1_oe", vram_wdata_oe, 0); chk("t1_busy", mpu_busy, 0);
        chk("t1_be_n", _vram_be, 2'b11);
        _mpu_en = 1; _mpu_wr = 1;
        tick(); tick();
        _reset = 1;
        tick();
        chk("t1_idle_en", _vram_en, 1); chk("t1_idle_busy", mpu_busy, 0);
        $display("[TB] reset mid-write released bus");

        // Overrun: second pulse while first request waits behind GPU traffic
        gpu_auto = 1; gpu_keep = 1;
        tick(); tick();
        mpu_start(1, 16'h0200, 16'h1111, 2'b00);
        wait_busy("t5_busy", 10);
        _mpu_en = 1;
        tick(); tick();
        mpu_start(1, 16'h0300, 16'h2222, 2'b10);
        repeat (4) tick();
        chk("t5_overrun", mpu_overrun, 1); chk("t5_still_busy", mpu_busy, 1);
        seen = 0; wd = 0; wa = 0;
        for (int i = 0; i < 40 && mpu_busy; i++) begin
            tick();
            if (!_vram_wr) begin seen = 1; wd = vram_wdata; wa = vram_addr; end
        end
        chk("t5_seen", seen, 1); chk("t5_wdata", wd, 16'h1111);
        chk("t5_waddr", wa, 16'h0200); chk("t5_done", mpu_busy, 0);
        _mpu_en = 1; _mpu_wr = 1;
        repeat (6) tick();
        chk("t5_no_second", mpu_busy, 0); chk("t5_sticky", mpu_overrun, 1);
        $display("[TB] overrun flagged, first write data %h", wd);

        // Starvation bound: MPU read under continuous GPU load
        mpu_start(0, 16'h0100, 16'h0000, 2'b00);
        wait_busy("t4_busy", 10);
        _mpu_en = 1;
        t = 0; acks = 0;
        for (int i = 0; i < 40 && mpu_busy; i++) begin
            tick();
            t++;
            if (gpu_ack) acks++;
        end
        chk("t4_latency_ok", (t >= 19 && t <= 21), 1);
        chk("t4_rdata", mpu_rdata, 16'h5A3D);
        chk("t4_gpu_acks", acks >= 5, 1);
        $display("[TB] starved MPU read done after %0d cycles, rdata %h", t, mpu_rdata);

        // Back-to-back GPU reads
        acks = 0; last = -1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (gpu_ack) begin
                chk("t6_idle_en", _vram_en, 1);
                if (last >= 0) chk("t6_spacing", cyc - last, 3);
                last = cyc; acks++;
            end
        end
        chk("t6_ack_count", acks >= 7, 1);
        $display("[TB] back-to-back GPU: %0d acks in 24 cycles", acks);

        // Randomized traffic from a fresh reset
        gpu_auto = 0; gpu_keep = 0; gpu_req = 0;
        _reset = 0;
        tick(); tick();
        _reset = 1;
        gpu_auto = 1; mpu_auto = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 30) == 0) hblank = !hblank;
            if ($urandom_range(0, 200) == 0) vblank = !vblank;
        end
        gpu_auto = 0; mpu_auto = 0; gpu_req = 0; _mpu_en = 1;
        repeat (40) tick();
        $display("[TB] random phase complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
